// File: rtl/m68k_bus_master_if.sv
// m68k_bus_master_if: request/response and 68008 bus signals of the bus-cycle initiator.
//   master modport (the initiator): req, we, addr, fc, wdata in; busy, done, status, rdata out;
//     a_out, fc_out, rw, as_n, ds_n, d_out, d_oe out; d_in, dtack_n, berr_n, vpa_n in.
//   slave modport: the requester plus bus target, all directions reversed.
interface m68k_bus_master_if #(parameter int ADDR_W = 22);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        fc;
    logic [7:0]        wdata;
    logic              busy;
    logic              done;
    logic [1:0]        status;
    logic [7:0]        rdata;
    logic [ADDR_W-1:0] a_out;
    logic [2:0]        fc_out;
    logic              rw;
    logic              as_n;
    logic              ds_n;
    logic [7:0]        d_out;
    logic              d_oe;
    logic [7:0]        d_in;
    logic              dtack_n;
    logic              berr_n;
    logic              vpa_n;
    modport master (
        input  req, we, addr, fc, wdata, d_in, dtack_n, berr_n, vpa_n,
        output busy, done, status, rdata, a_out, fc_out, rw, as_n, ds_n, d_out, d_oe
    );
    modport slave (
        output req, we, addr, fc, wdata, d_in, dtack_n, berr_n, vpa_n,
        input  busy, done, status, rdata, a_out, fc_out, rw, as_n, ds_n, d_out, d_oe
    );
endinterface

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: 68008-style single-beat bus-cycle initiator (AS_n/DS_n/RW).
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : m68k_bus_master_if.master -- request (req/we/addr/fc/wdata),
//              response (busy/done/status/rdata), bus (a_out/fc_out/rw/as_n/ds_n/
//              d_out/d_oe/d_in) and terminations (dtack_n/berr_n/vpa_n).
//   status: 00 DTACK, 01 BERR, 10 timeout, 11 VPA; published with done.
module m68k_bus_master #(
    parameter int ADDR_W         = 22,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst,
    m68k_bus_master_if.master bus
);
    localparam int TMAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int CW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, ASRT, DSTB, WAIT, END} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    sts;
    logic          timed_out;

    assign timed_out = (TIMEOUT_CYCLES > 0) && (cnt == CW'(TMAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sts        <= 2'b00;
            bus.as_n   <= 1'b1;
            bus.ds_n   <= 1'b1;
            bus.rw     <= 1'b1;
            bus.d_oe   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.status <= 2'b00;
            bus.rdata  <= 8'h00;
            bus.a_out  <= '0;
            bus.fc_out <= 3'b000;
            bus.d_out  <= 8'h00;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    // data hold from a preceding write ends here
                    bus.d_oe <= 1'b0;
                    bus.rw   <= 1'b1;
                    if (bus.req) begin
                        bus.a_out  <= ADDR_W'(bus.addr);
                        bus.fc_out <= bus.fc;
                        bus.rw     <= ~bus.we;
                        bus.d_out  <= bus.wdata;
                        bus.busy   <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: state <= ASRT;
                ASRT: begin
                    bus.as_n <= 1'b0;
                    cnt      <= '0;
                    if (bus.rw) begin
                        bus.ds_n <= 1'b0;
                        state    <= WAIT;
                    end else begin
                        bus.d_oe <= 1'b1;
                        state    <= DSTB;
                    end
                end
                DSTB: begin
                    bus.ds_n <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // status is staged in sts so the visible status only changes with done
                    state <= END;
                    if (!bus.berr_n) begin
                        sts <= 2'b01;
                    end else if (!bus.dtack_n) begin
                        sts <= 2'b00;
                        if (bus.rw) bus.rdata <= bus.d_in;
                    end else if (!bus.vpa_n) begin
                        sts <= 2'b11;
                    end else if (timed_out) begin
                        sts <= 2'b10;
                    end else begin
                        state <= WAIT;
                        cnt   <= cnt + 1'b1;
                    end
                end
                END: begin
                    bus.as_n   <= 1'b1;
                    bus.ds_n   <= 1'b1;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    bus.status <= sts;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
